seq_detector_param: RTL and testbench

Parametrised serial pattern detector: the next generation of the fixed 4-bit "1101" Moore detector in the StateMachine library. It watches a qualified serial bit stream and raises a registered, Moore-style one-cycle `detect` pulse each time the last N accepted bits equal a pattern. The pattern is a parameter default that can be reloaded at runtime, overlap is selectable, and detections are counted with saturation. It sits between a serial receiver/deserializer front end and control logic that reacts to framing or sync words.

---
 rtl/seq_detector_param.sv | 94 +++++++++
 tb/tb_seq_detector_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial pattern detector. Watches a qualified bit stream and raises a
//   registered one-cycle detect pulse each time the last N accepted bits
//   equal the current pattern. The pattern resets to PATTERN and can be
//   reloaded at runtime. Overlapping matches are optional. Detections are
//   counted in a saturating counter.
//
// Parameters
//   N        pattern length, 2..32
//   PATTERN  reset-time pattern; PATTERN[N-1] is the oldest bit
//   OVERLAP  1: matches may share bits, 0: search restarts after a match
//   CNT_W    width of match_count
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en           accept input_bit on this edge
//   input_bit    serial data
//   load         capture pattern_in and restart the search (wins over en)
//   pattern_in   new pattern, MSB first
//   count_clr    synchronous clear of match_count (wins over an increment)
//   detect       registered match pulse
//   match_count  saturating detection count
module seq_detector_param #(
    parameter int            N       = 4,
    parameter logic [N-1:0]  PATTERN = 4'b1101,
    parameter bit            OVERLAP = 1'b1,
    parameter int            CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             input_bit,
    input  logic             load,
    input  logic [N-1:0]     pattern_in,
    input  logic             count_clr,
    output logic             detect,
    output logic [CNT_W-1:0] match_count
);

    if (N < 2 || N > 32) begin : g_bad_n
        $fatal(1, "seq_detector_param: N must be in 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $fatal(1, "seq_detector_param: CNT_W must be at least 1");
    end

    localparam int             FW   = $clog2(N + 1);
    localparam logic [FW-1:0]  FULL = FW'(N);

    logic [N-1:0]  pat_r;
    logic [N-1:0]  hist;
    logic [FW-1:0] fill;

    logic [N-1:0]  hist_next;
    logic [FW-1:0] fill_next;
    logic          match;

    // fill saturates at N: once the window is full it stays full.
    assign hist_next = {hist[N-2:0], input_bit};
    assign fill_next = (fill == FULL) ? fill : fill + 1'b1;
    assign match     = en && !load && (fill_next == FULL) && (hist_next == pat_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r       <= PATTERN;
            hist        <= '0;
            fill        <= '0;
            detect      <= 1'b0;
            match_count <= '0;
        end else begin
            detect <= match;

            if (load) begin
                pat_r <= pattern_in;
                hist  <= '0;
                fill  <= '0;
            end else if (en) begin
                hist <= hist_next;
                // Without overlap the next match must be built from N fresh bits.
                if (match && !OVERLAP)
                    fill <= '0;
                else
                    fill <= fill_next;
            end

            if (count_clr)
                match_count <= '0;
            else if (match && !(&match_count))
                match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Two instances share one stimulus stream:
// u0 uses the defaults (overlap, 8-bit count), u1 uses OVERLAP=0, CNT_W=2.
// A behavioural model tracks, per instance, how many bits were accepted since
// the search last restarted and the most recent four bits as a number.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en = 1'b0;
    logic       input_bit = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pattern_in = 4'b0000;
    logic       count_clr = 1'b0;

    logic       det0, det1;
    logic [7:0] mc0;
    logic [1:0] mc1;

    int nchk  = 0;
    int nfail = 0;

    // model state, index 0 -> u0, 1 -> u1
    int         nb   [2];
    int         win  [2];
    int         pat  [2];
    int         edet [2];
    int         ecnt [2];

    always #5 clk = ~clk;

    seq_detector_param u0 (
        .clk(clk), .rst(rst), .en(en), .input_bit(input_bit), .load(load),
        .pattern_in(pattern_in), .count_clr(count_clr),
        .detect(det0), .match_count(mc0)
    );

    seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .input_bit(input_bit), .load(load),
        .pattern_in(pattern_in), .count_clr(count_clr),
        .detect(det1), .match_count(mc1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            nb[k] = 0; win[k] = 0; pat[k] = 13; edet[k] = 0; ecnt[k] = 0;
        end
    endtask

    // One clock edge worth of the model, using the inputs present at the edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int cmax;
            cmax = (k == 0) ? 255 : 3;
            edet[k] = 0;
            if (load) begin
                pat[k] = int'(pattern_in);
                nb[k]  = 0;
                win[k] = 0;
            end else if (en) begin
                win[k] = (win[k] * 2 + int'(input_bit)) % 16;
                nb[k]  = nb[k] + 1;
                if (nb[k] >= 4 && win[k] == pat[k]) begin
                    edet[k] = 1;
                    if (ecnt[k] < cmax) ecnt[k] = ecnt[k] + 1;
                    if (k == 1) nb[k] = 0;
                end
            end
            if (count_clr) ecnt[k] = 0;
        end
    endtask

    task automatic step(input logic e, input logic b, input logic ld,
                        input logic [3:0] p, input logic c);
        en = e; input_bit = b; load = ld; pattern_in = p; count_clr = c;
        @(posedge clk);
        model_edge();
        #1;
        en = 1'b0; load = 1'b0; count_clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_load(input logic [3:0] p);
        step(1'b0, 1'b0, 1'b1, p, 1'b0);
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("model det0", int'(det0), edet[0]);
            chk("model mc0",  int'(mc0),  ecnt[0]);
            chk("model det1", int'(det1), edet[1]);
            chk("model mc1",  int'(mc1),  ecnt[1]);
        end
    end

    initial begin
        logic [7:0] v;
        rst = 1'b1;
        model_reset();
        #12;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset det0", int'(det0), 0);
        chk("reset mc0",  int'(mc0),  0);

        // basic 1101
        send(8'b110, 3);
        chk("pre det0", int'(det0), 0);
        send(8'b1, 1);
        chk("1101 det0", int'(det0), 1);
        chk("1101 mc0",  int'(mc0),  1);
        chk("1101 det1", int'(det1), 1);
        // continue to 1101101: overlap sees a second match, non-overlap not
        send(8'b101, 3);
        chk("ovl det0", int'(det0), 1);
        chk("ovl mc0",  int'(mc0),  2);
        chk("novl det1", int'(det1), 0);
        chk("novl mc1",  int'(mc1),  1);

        // extra leading 1
        do_load(4'b1101);
        send(8'b1110, 4);
        chk("11101 pre det0", int'(det0), 0);
        send(8'b1, 1);
        chk("11101 det0", int'(det0), 1);
        chk("11101 det1", int'(det1), 1);
        chk("11101 mc0",  int'(mc0),  3);

        // en gaps are transparent
        do_load(4'b1101);
        v = 8'b1101;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, v[i], 1'b0, 4'h0, 1'b0);
            if (i != 0) for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        end
        chk("gap det0", int'(det0), 1);
        chk("gap mc0",  int'(mc0),  4);

        // load mid-pattern discards history
        send(8'b110, 3);
        do_load(4'b0110);
        send(8'b0110, 4);
        chk("load0110 det0", int'(det0), 1);
        chk("load0110 mc0",  int'(mc0),  5);
        send(8'b1101, 4);
        chk("old pat det1", int'(det1), 0);

        // load together with en: that bit is dropped
        step(1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
        send(8'b101, 3);
        chk("load+en det0", int'(det0), 0);
        chk("load+en det1", int'(det1), 0);

        // saturation on the 2-bit counter
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        chk("clr mc1", int'(mc1), 0);
        do_load(4'b1101);
        for (int r = 0; r < 5; r++) begin
            send(8'b1101, 4);
            chk("sat det1", int'(det1), 1);
            chk("sat mc1",  int'(mc1), (r < 3) ? r + 1 : 3);
        end

        // clear coinciding with a match
        send(8'b110, 3);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
        chk("clr+match det1", int'(det1), 1);
        chk("clr+match mc1",  int'(mc1),  0);
        chk("clr+match det0", int'(det0), 1);
        chk("clr+match mc0",  int'(mc0),  0);

        // async reset mid-pattern after a load
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        do_load(4'b0110);
        send(8'b1, 1);
        send(8'b1, 1);   // leave the counters nonzero? use a match first
        send(8'b0, 1);
        send(8'b110, 3); // 0110 completes -> counts nonzero before reset
        chk("pre-rst mc0", int'(mc0), 1);
        send(8'b110, 3);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst det0", int'(det0), 0);
        chk("rst mc0",  int'(mc0),  0);
        chk("rst det1", int'(det1), 0);
        chk("rst mc1",  int'(mc1),  0);
        #3 rst = 1'b0;
        send(8'b1, 1);
        chk("lone1 det0", int'(det0), 0);
        send(8'b110, 3);
        chk("post-rst pre det0", int'(det0), 0);
        send(8'b1, 1);
        chk("post-rst det0", int'(det0), 1);
        chk("post-rst mc0",  int'(mc0),  1);
        chk("post-rst det1", int'(det1), 1);

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            logic e, b, ld, c;
            e  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom_range(0, 1));
            ld = ($urandom_range(0, 49) == 0);
            c  = ($urandom_range(0, 99) == 0);
            step(e, b, ld, 4'($urandom_range(0, 15)), c);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
